// File: rtl/memory_32k_ws.sv
// Wait-stated 36-bit word memory behind an Avalon-MM slave port, for the core-memory controller.
// Define MEM_PARITY_EN to store an even-parity bit per word and flag read-back parity errors.
module memory_32k_ws #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [35:0] s_writedata,
  output logic [35:0] s_readdata,
  output logic        s_waitrequest,
  output logic        o_busy
`ifdef MEM_PARITY_EN
  ,
  input  logic        force_bad_parity,
  output logic        o_parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = 37;
`else
  localparam int MEM_W = 36;
`endif
  localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   op_write;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [35:0]            data_q;
  logic [MEM_W-1:0]       mem [DEPTH];

  logic                   req;
  logic                   acc;
  logic                   acc_write;
  logic [ADDR_BITS-1:0]   acc_idx;
  logic [35:0]            acc_data;
  logic                   we;
  logic                   re;
  logic [MEM_W-1:0]       store_word;

  function automatic logic even_par(input logic [35:0] d);
    return ^d;
  endfunction

  if (ADDR_BITS < 18) begin : g_addr_tie
    logic unused_addr_hi;
    assign unused_addr_hi = ^s_address[17:ADDR_BITS];
  end

  assign req = s_read | s_write;

  // With zero wait states the access uses the live bus; otherwise it uses the latched request.
  always_comb begin
    acc       = 1'b0;
    acc_write = op_write;
    acc_idx   = addr_q;
    acc_data  = data_q;
    if (ZERO_WAIT && state == IDLE && req) begin
      acc       = 1'b1;
      acc_write = s_write;
      acc_idx   = s_address[ADDR_BITS-1:0];
      acc_data  = s_writedata;
    end else if (state == BUSY && cnt == 4'd1) begin
      acc = 1'b1;
    end
  end

  // Write wins over read; reset gating keeps a discarded write off the array.
  assign we = acc & acc_write & ~reset;
  assign re = acc & ~acc_write;

`ifdef MEM_PARITY_EN
  assign store_word = {even_par(acc_data) ^ force_bad_parity, acc_data};
`else
  assign store_word = acc_data;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[acc_idx] <= store_word;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_q <= s_address[ADDR_BITS-1:0];
      data_q <= s_writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      op_write      <= 1'b0;
      s_readdata    <= 36'd0;
      s_waitrequest <= 1'b1;
      o_busy        <= 1'b0;
`ifdef MEM_PARITY_EN
      o_parity_err  <= 1'b0;
`endif
    end else begin
      if (re) begin
        s_readdata <= mem[acc_idx][35:0];
`ifdef MEM_PARITY_EN
        if (^mem[acc_idx]) o_parity_err <= 1'b1;
`endif
      end
      unique case (state)
        IDLE: begin
          if (req) begin
            op_write <= s_write;
            o_busy   <= 1'b1;
            if (ZERO_WAIT) begin
              state         <= DONE;
              cnt           <= 4'd0;
              s_waitrequest <= 1'b0;
            end else begin
              state <= BUSY;
              cnt   <= WAIT_LD;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state         <= DONE;
            s_waitrequest <= 1'b0;
          end
        end
        DONE: begin
          state         <= IDLE;
          s_waitrequest <= 1'b1;
          o_busy        <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          s_waitrequest <= 1'b1;
          o_busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_32k_ws.md
MEMORY_32K_WS -- requirements
Module: memory_32k_ws

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, range 0..15: clock cycles a request is held off before completing.
REQ-002 Parameter ADDR_BITS, default 15: index width; depth 2**ADDR_BITS words of 36 bits.
REQ-003 Port clk, input, 1: the block's single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port s_address, input, 18: word address from the core-memory controller (Avalon-MM slave side).
REQ-006 Port s_read, input, 1: read request.
REQ-007 Port s_write, input, 1: write request.
REQ-008 Port s_writedata, input, 36: write word.
REQ-009 Port s_readdata, output, 36: registered read word.
REQ-010 Port s_waitrequest, output, 1: high = transfer not complete; master holds request.
REQ-011 Port o_busy, output, 1: high while a request is latched and not yet completed.

Function
REQ-012 FSM states IDLE, BUSY and DONE SHALL be the only states.
REQ-013 IDLE with s_read or s_write high at a clock edge: latch address, data and op, load counter with WAIT_CYCLES, go to BUSY; if WAIT_CYCLES=0, go directly to DONE.
REQ-014 BUSY: decrement counter each cycle; when counter reaches 1, perform the access and go to DONE on the same edge.
REQ-015 Access: write stores the latched data at index address[ADDR_BITS-1:0]; read loads s_readdata from that index.
REQ-016 DONE lasts exactly one cycle, then returns to IDLE.
REQ-017 s_waitrequest SHALL be low only in DONE and high in IDLE and BUSY.
REQ-018 Latency: request sampled at edge N; s_waitrequest low during cycle N+WAIT_CYCLES+1.
REQ-019 s_readdata holds its value until the next read completes; writes do not change it.
REQ-020 Simultaneous s_read and s_write: only the write is performed; s_readdata is unchanged.
REQ-021 Address bits above ADDR_BITS are ignored; accesses wrap modulo depth.
REQ-022 Changes to s_address, s_writedata, s_read or s_write after latching SHALL NOT affect the access in flight.
REQ-023 A request still asserted in the DONE cycle SHALL NOT be re-accepted; a new request is accepted only from IDLE.
REQ-024 o_busy is high in BUSY and DONE.

Reset
REQ-025 reset SHALL force IDLE, counter 0, s_readdata 0, s_waitrequest 1 and o_busy 0 immediately, without waiting for a clock edge.
REQ-026 Reset during BUSY discards the pending access; a pending write SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro MEM_PARITY_EN defined:
- each word is stored with an even-parity bit;
- every completed read recomputes parity;
- on a mismatch, output o_parity_err (1 bit) is set and stays set until reset;
- the test hook force_bad_parity (input, 1) stores an inverted parity bit on writes while high.
REQ-029 Without MEM_PARITY_EN: no parity storage, o_parity_err and force_bad_parity are absent, and behaviour is otherwise identical.

Verification
REQ-030 WAIT_CYCLES=2: write 36'o123321456654 to 'o1000, then read 'o1000 -> s_waitrequest low 3 cycles after each request; s_readdata = 36'o123321456654.
REQ-031 WAIT_CYCLES=0: read 'o42 preloaded with 36'o334000000000 -> s_waitrequest low in the cycle after the request; s_readdata = 36'o334000000000.
REQ-032 s_read and s_write both high, address 'o100, data 36'o202000001000 -> word stored; s_readdata keeps its prior value; readback returns 36'o202000001000.
REQ-033 Write 36'o777 to address 18'o401000 -> read of 'o1000 returns 36'o777 (wrap).
REQ-034 reset pulsed in BUSY of a write of 36'o1 to 'o50 holding 0 -> s_waitrequest=1 and o_busy=0 immediately; later read of 'o50 returns 0.
REQ-035 MEM_PARITY_EN defined: write 'o43 with force_bad_parity=1, then read 'o43 -> o_parity_err=1 after DONE and held until reset.
